// File: rtl/pico_core_seq.sv
// pico_core_seq: multi-cycle SUBLEQ/MULTI processor core.
// Instructions come from an external synchronous ROM. The register file has a
// hard-wired zero register, and its top register maps to switch input and LED
// output. MULTI uses an iterative signed shift-add multiplier.
// Optional build macro: SAT_ARITH_EN makes both results saturate instead of wrap.
module pico_core_seq #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned NREGS     = 4,
   parameter int unsigned PA        = 8,
   parameter int unsigned IMM_W     = 8,
   parameter int unsigned FRAC_BITS = 7,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    run,
   input  logic [DATA_W-1:0]                       sw_in,
   output logic [DATA_W-1:0]                       led_out,
   output logic [PA-1:0]                           imem_addr,
   output logic                                    imem_rd,
   input  logic [1+2*$clog2(NREGS)+2*PA-1:0]       imem_data,
   output logic [PA-1:0]                           pc_out,
   output logic                                    busy,
   output logic                                    halted
);

   localparam int unsigned RA = $clog2(NREGS);
   localparam int unsigned IW = 1 + 2*RA + 2*PA;
   localparam int unsigned P  = DATA_W + IMM_W;
   localparam int unsigned CW = $clog2(IMM_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(IMM_W - 1);
   localparam logic [RA-1:0] IO_REG   = RA'(NREGS - 1);

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MUL, S_WRITE} state_t;

   state_t state, state_nx;

   logic [DATA_W-1:0] regs [NREGS];
   logic [PA-1:0]     pc;

   // Instruction fields, taken straight off the ROM output during DECODE
   logic              op_d;
   logic [RA-1:0]     r1_d, r2_d;
   logic [PA-1:0]     fa_d, fn_d;
   logic [IMM_W-1:0]  imm_d;

   // Values latched at DECODE for use in MUL/WRITE
   logic              is_mul;
   logic [RA-1:0]     rd_q;
   logic [PA-1:0]     fa_q, fn_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] a_rd, b_rd;

   // Shift-add multiplier state
   logic [P-1:0]      mcand;
   logic [P-1:0]      acc;
   logic [IMM_W-1:0]  mplier;
   logic [CW-1:0]     cnt;

   logic [DATA_W-1:0] sub_res, mul_res, res;
   logic              take_branch;
   logic [PA-1:0]     next_pc;

`ifdef SAT_ARITH_EN
   localparam logic signed [P-1:0] SMAX = {{(P-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [P-1:0] SMIN = {{(P-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   logic signed [DATA_W:0] diff;
   logic signed [P-1:0]    shifted;
`endif

   assign op_d  = imem_data[IW-1];
   assign r1_d  = imem_data[IW-2 -: RA];
   assign r2_d  = imem_data[IW-2-RA -: RA];
   assign fa_d  = imem_data[2*PA-1:PA];
   assign fn_d  = imem_data[PA-1:0];
   assign imm_d = imem_data[2*PA-1 -: IMM_W];

   assign imem_addr = pc;
   assign pc_out    = pc;

   // Operand read: register 0 is zero, the top register reads the switches
   always_comb begin
      a_rd = '0;
      b_rd = '0;
      if (r1_d == IO_REG)
         a_rd = sw_in;
      else if (r1_d != '0)
         a_rd = regs[r1_d];
      if (r2_d == IO_REG)
         b_rd = sw_in;
      else if (r2_d != '0)
         b_rd = regs[r2_d];
   end

   // Result selection, branch decision and next program counter
   always_comb begin
`ifdef SAT_ARITH_EN
      diff    = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};
      shifted = $signed(acc) >>> FRAC_BITS;
      if (diff[DATA_W] != diff[DATA_W-1])
         sub_res = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         sub_res = diff[DATA_W-1:0];
      if (shifted > SMAX)
         mul_res = {1'b0, {(DATA_W-1){1'b1}}};
      else if (shifted < SMIN)
         mul_res = {1'b1, {(DATA_W-1){1'b0}}};
      else
         mul_res = shifted[DATA_W-1:0];
`else
      sub_res = a_q - b_q;
      mul_res = DATA_W'($signed(acc) >>> FRAC_BITS);
`endif
      res         = is_mul ? mul_res : sub_res;
      take_branch = !is_mul && (res[DATA_W-1] || (res == '0));
      next_pc     = take_branch ? fa_q : fn_q;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= state_nx;
   end

   // FSM next state, ROM read strobe and busy flag
   always_comb begin
      state_nx = state;
      imem_rd  = 1'b0;
      busy     = (state != S_FETCH);
      case (state)
         S_FETCH: begin
            if (run && !halted && !reset) begin
               imem_rd  = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: state_nx = op_d ? S_MUL : S_WRITE;
         S_MUL:    if (cnt == CNT_LAST) state_nx = S_WRITE;
         S_WRITE:  state_nx = S_FETCH;
         default:  state_nx = S_FETCH;
      endcase
   end

   // Datapath: decode latch, multiplier iteration, register write and pc update
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= PA'(RESET_PC);
         halted  <= 1'b0;
         led_out <= '0;
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
         is_mul  <= 1'b0;
         rd_q    <= '0;
         fa_q    <= '0;
         fn_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mcand   <= '0;
         acc     <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            S_DECODE: begin
               is_mul <= op_d;
               rd_q   <= r1_d;
               fa_q   <= fa_d;
               fn_q   <= fn_d;
               a_q    <= a_rd;
               b_q    <= b_rd;
               mcand  <= P'($signed(a_rd));
               mplier <= imm_d;
               acc    <= '0;
               cnt    <= '0;
            end
            S_MUL: begin
               // Multiplier MSB carries negative weight in two's complement,
               // so the final partial product is subtracted.
               if (mplier[0])
                  acc <= (cnt == CNT_LAST) ? (acc - mcand) : (acc + mcand);
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            S_WRITE: begin
               if (rd_q == IO_REG)
                  led_out <= res;
               else if (rd_q != '0)
                  regs[rd_q] <= res;
               pc <= next_pc;
               if (next_pc == pc)
                  halted <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pico_core_seq.sv
// tb_pico_core_seq: directed and randomized checks of pico_core_seq against an
// arithmetic reference model of the instruction set.
module tb_pico_core_seq;

   localparam int DATA_W    = 8;
   localparam int NREGS     = 4;
   localparam int PA        = 8;
   localparam int IMM_W     = 8;
   localparam int FRAC_BITS = 7;
   localparam int RESET_PC  = 0;
   localparam int RA        = 2;
   localparam int IW        = 1 + 2*RA + 2*PA;

   logic              clk = 1'b0;
   logic              reset;
   logic              run;
   logic [DATA_W-1:0] sw_in;
   logic [DATA_W-1:0] led_out;
   logic [PA-1:0]     imem_addr;
   logic              imem_rd;
   logic [IW-1:0]     imem_data;
   logic [PA-1:0]     pc_out;
   logic              busy;
   logic              halted;

   logic [IW-1:0] rom [256];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int         mregs [NREGS];
   logic [7:0] m_pc;
   logic [7:0] m_led;
   logic       m_halt;

   pico_core_seq #(
      .DATA_W   (DATA_W),
      .NREGS    (NREGS),
      .PA       (PA),
      .IMM_W    (IMM_W),
      .FRAC_BITS(FRAC_BITS),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .sw_in    (sw_in),
      .led_out  (led_out),
      .imem_addr(imem_addr),
      .imem_rd  (imem_rd),
      .imem_data(imem_data),
      .pc_out   (pc_out),
      .busy     (busy),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   // Synchronous instruction ROM
   always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input logic op, input logic [1:0] r1,
                                         input logic [1:0] r2, input logic [7:0] fa,
                                         input logic [7:0] fn);
      return {op, r1, r2, fa, fn};
   endfunction

   function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x;
      do x = 8'($urandom); while (x == a || x == b);
      return x;
   endfunction

   function automatic int m_rd(input int idx, input logic [7:0] sw);
      if (idx == 0) return 0;
      if (idx == NREGS-1) return int'($signed(sw));
      return mregs[idx];
   endfunction

   function automatic int fit(input int v);
`ifdef SAT_ARITH_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
`else
      logic signed [7:0] t;
      t = v[7:0];
      return int'(t);
`endif
   endfunction

   task automatic m_step(input logic [IW-1:0] ins, input logic [7:0] sw, output int lat);
      logic                    op;
      int                      r1, r2, a, b, res;
      logic [7:0]              fa, fn, npc;
      logic [15:0]             pair;
      logic signed [IMM_W-1:0] imm;
      op   = ins[IW-1];
      r1   = int'(ins[IW-2 -: 2]);
      r2   = int'(ins[IW-4 -: 2]);
      fa   = ins[15:8];
      fn   = ins[7:0];
      pair = {fa, fn};
      imm  = pair[15 -: IMM_W];
      a    = m_rd(r1, sw);
      b    = m_rd(r2, sw);
      if (!op) begin
         res = fit(a - b);
         npc = (res <= 0) ? fa : fn;
         lat = 3;
      end else begin
         res = fit((a * int'(imm)) >>> FRAC_BITS);
         npc = fn;
         lat = 3 + IMM_W;
      end
      if (r1 == NREGS-1) m_led = res[7:0];
      else if (r1 != 0) mregs[r1] = res;
      if (npc == m_pc) m_halt = 1'b1;
      m_pc = npc;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd",   32'(imem_rd), 32'd0);
      chk("rst_pc",   32'(pc_out),  32'(RESET_PC));
      chk("rst_busy", 32'(busy),    32'd0);
      chk("rst_halt", 32'(halted),  32'd0);
      chk("rst_led",  32'(led_out), 32'd0);
      reset  = 1'b0;
      run    = 1'b0;
      m_pc   = 8'(RESET_PC);
      m_led  = '0;
      m_halt = 1'b0;
      for (int i = 0; i < NREGS; i++) mregs[i] = 0;
   endtask

   // Issue one instruction at the model pc and check its whole lifetime
   task automatic run_instr(input logic [IW-1:0] ins, input logic [7:0] sw);
      int         lat, cyc;
      logic [7:0] pc0;
      pc0      = m_pc;
      rom[pc0] = ins;
      sw_in    = sw;
      run      = 1'b1;
      m_step(ins, sw, lat);
      #1;
      chk("fetch_rd",   32'(imem_rd),   32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(pc0));
      chk("fetch_busy", 32'(busy),      32'd0);
      @(posedge clk); #1;
      cyc = 1;
      run = 1'($urandom_range(0, 1));
      chk("decode_rd",   32'(imem_rd), 32'd0);
      chk("decode_busy", 32'(busy),    32'd1);
      while (busy && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      run = 1'b0;
      chk("latency", 32'(cyc),     32'(lat));
      chk("pc",      32'(pc_out),  32'(m_pc));
      chk("led",     32'(led_out), 32'(m_led));
      chk("halted",  32'(halted),  32'(m_halt));
   endtask

   // Load register k with val through the switch register; leaves pc at land
   task automatic set_reg(input logic [1:0] k, input logic [7:0] val, input logic [7:0] land);
      logic [7:0] mid;
      mid = pick(m_pc, land);
      run_instr(enc(1'b0, k, k, mid, mid), 8'($urandom));
      run_instr(enc(1'b0, k, 2'd3, land, land), 8'(-val));
   endtask

   // Copy -R[k] to the LEDs
   task automatic rd_back(input logic [1:0] k);
      logic [7:0] mid;
      mid = pick(m_pc, m_pc);
      run_instr(enc(1'b0, 2'd3, k, mid, mid), 8'd0);
   endtask

   task automatic rand_instr();
      logic [7:0] sw;
      case ($urandom_range(0, 7))
         0:       sw = 8'h80;
         1:       sw = 8'h7F;
         2:       sw = 8'h00;
         3:       sw = 8'hFF;
         default: sw = 8'($urandom);
      endcase
      run_instr(enc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), pick(m_pc, m_pc), pick(m_pc, m_pc)), sw);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      sw_in = '0;
      for (int i = 0; i < 256; i++) rom[i] = '0;
      do_reset();

      // First fetch from reset: 0 - 0 branches to fa
      run_instr(enc(1'b0, 2'd1, 2'd1, 8'd5, 8'd1), 8'd0);
      chk("t1_pc", 32'(pc_out), 32'd5);

      // 10 - 3 = 7, no branch
      set_reg(2'd1, 8'd10, 8'd20);
      set_reg(2'd2, 8'd3, 8'd30);
      run_instr(enc(1'b0, 2'd1, 2'd2, 8'd9, 8'd2), 8'd0);
      chk("sub_pos_pc", 32'(pc_out), 32'd2);
      rd_back(2'd1);
      chk("sub_pos_val", 32'(led_out), 32'hF9);

      // 10 - 20 = -10, branch
      set_reg(2'd1, 8'd10, 8'd20);
      set_reg(2'd2, 8'd20, 8'd30);
      run_instr(enc(1'b0, 2'd1, 2'd2, 8'd9, 8'd2), 8'd0);
      chk("sub_neg_pc", 32'(pc_out), 32'd9);
      rd_back(2'd1);
      chk("sub_neg_val", 32'(led_out), 32'h0A);

      // 0.5 * 0.5 and 0.5 * -0.5 in Q1.7
      set_reg(2'd1, 8'h40, 8'd40);
      run_instr(enc(1'b1, 2'd1, 2'd0, 8'h40, 8'd50), 8'd0);
      chk("mul_pos_pc", 32'(pc_out), 32'd50);
      rd_back(2'd1);
      chk("mul_pos_val", 32'(led_out), 32'hE0);
      set_reg(2'd1, 8'h40, 8'd40);
      run_instr(enc(1'b1, 2'd1, 2'd0, 8'hC0, 8'd50), 8'd0);
      rd_back(2'd1);
      chk("mul_neg_val", 32'(led_out), 32'h20);

      // Switch to LED path, and writes to register 0 are discarded
      run_instr(enc(1'b0, 2'd3, 2'd0, pick(m_pc, m_pc), pick(m_pc, m_pc)), 8'h2A);
      chk("led_sw", 32'(led_out), 32'h2A);
      run_instr(enc(1'b0, 2'd0, 2'd3, pick(m_pc, m_pc), pick(m_pc, m_pc)), 8'h05);
      rd_back(2'd0);
      chk("zero_reg", 32'(led_out), 32'h00);

      // With run low the core idles in FETCH
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_rd",   32'(imem_rd), 32'd0);
         chk("idle_busy", 32'(busy),    32'd0);
      end

      // Reset in the middle of a multiply: no write-back
      set_reg(2'd1, 8'h40, 8'd60);
      rom[m_pc] = enc(1'b1, 2'd1, 2'd2, 8'h40, 8'd70);
      sw_in = 8'd0;
      run   = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_mul_busy", 32'(busy), 32'd1);
      do_reset();
      run_instr(enc(1'b0, 2'd3, 2'd1, 8'd7, 8'd8), 8'h11);
      chk("mid_mul_abort", 32'(led_out), 32'h11);

      // Random instruction stream
      repeat (150) rand_instr();

      // Self-loop halts the core for good
      run_instr(enc(1'b0, 2'd2, 2'd1, m_pc, m_pc), 8'($urandom));
      chk("halt_set", 32'(halted), 32'd1);
      run = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("halt_rd",   32'(imem_rd), 32'd0);
         chk("halt_busy", 32'(busy),    32'd0);
      end
      run = 1'b0;
      chk("halt_pc", 32'(pc_out), 32'(m_pc));
      do_reset();

      repeat (40) rand_instr();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
